// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared states, funct3 encodings and access-size decode for the load/store sequencer
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W; any other encoding, load or store, is a word access.
    function automatic acc_size_t access_size(input logic we, input logic [2:0] funct3);
        acc_size_t sz;
        sz = SZ_WORD;
        if (funct3 == F3_B || (!we && funct3 == F3_BU)) begin
            sz = SZ_BYTE;
        end else if (funct3 == F3_H || (!we && funct3 == F3_HU)) begin
            sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - lane extraction with sign/zero extension for loads and lane merge for sub-word stores
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = word[{addr_lo[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            F3_W:    load_data = word;
            default: load_data = word;
        endcase

        merge_word = word;
        case (access_size(1'b1, funct3))
            SZ_BYTE: merge_word[{addr_lo, 3'b000} +: 8]     = store_data[7:0];
            SZ_HALF: merge_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            default: merge_word = store_data;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// rtl/dmem_lsu_ctrl.sv - byte/half/word load-store sequencer with RMW sub-word stores
// Optional: define MISALIGN_TRAP_EN to report misaligned accesses instead of forcing alignment.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 11
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_addr_i,
    input  logic [WIDTH-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_rdata_o,
    output logic             rsp_misalign_o,
    output logic [31:0]      mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic             mem_we_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    lsu_state_t          state, next_state;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [WIDTH-1:0]    wdata_q, merge_q, rdata_q;
    logic                mis_q, rsp_valid_q;
    logic [WIDTH-1:0]    load_data, merge_word;
    logic                accept, misalign_req, store_is_word;
    logic                unused_addr_hi;

    assign accept         = req_valid_i && (state == IDLE);
    assign store_is_word  = (access_size(1'b1, f3_q) == SZ_WORD);
    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (access_size(req_we_i, req_funct3_i))
            SZ_HALF: misalign_req = req_addr_i[0];
            SZ_WORD: misalign_req = |req_addr_i[1:0];
            default: misalign_req = 1'b0;
        endcase
    end
`else
    assign misalign_req = 1'b0;
`endif

    dmem_lsu_align u_align (
        .word       (mem_rdata_i),
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid_i) next_state = misalign_req ? RESP : ACCESS;
            ACCESS:  next_state = (we_q && !store_is_word) ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes depend only on state and latched request, never on req_*.
    always_comb begin
        req_ready_o = (state == IDLE);
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state)
            ACCESS: if (we_q && store_is_word) begin
                mem_we_o    = 1'b1;
                mem_wdata_o = wdata_q;
            end
            WRITE: begin
                mem_we_o    = 1'b1;
                mem_wdata_o = merge_q;
            end
            default: ;
        endcase
    end

    assign mem_addr_o     = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rdata_q;
    assign rsp_misalign_o = mis_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            rdata_q     <= '0;
            mis_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            // The completion pulse trails RESP by one cycle, freeing IDLE for the next accept.
            rsp_valid_q <= (state == RESP);
            if (accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i[ADDR_W+1:0];
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                mis_q   <= misalign_req;
            end
            if (state == ACCESS) begin
                if (!we_q) rdata_q <= load_data;
                merge_q <= merge_word;
            end
        end
    end

endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store sequencer between the multicycle core FSM and the word-addressed data memory. It accepts one byte, halfword or word request at a time and converts the byte address to a word index. Loads are extracted and sign- or zero-extended. Sub-word stores are performed as read-modify-write because the memory only writes whole words. The block sits between the core's memory-stage control and the data memory, and is the only master of the memory port.

## Interface
- WIDTH, 32: data word width; only 32 is supported.
- ADDR_W, 11: word-index bits actually decoded by the memory (2048 words).

- clk_i  in  1  clock; all flops on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  WIDTH  store data; the low byte/half is used for sub-word stores.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  WIDTH  extended load data; 0 for stores.
- rsp_misalign_o  out  1  misaligned-access flag, qualified by rsp_valid_o.
- mem_addr_o  out  32  word index {zeros, addr[ADDR_W+1:2]}.
- mem_wdata_o  out  WIDTH  word to write.
- mem_we_o  out  1  memory write enable.
- mem_rdata_i  in  WIDTH  combinational read data for mem_addr_o.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i, latch we, funct3, addr and wdata.
  - Next state is ACCESS, or RESP directly if the access is misaligned (see Configuration).
- **ACCESS**
  - Drive mem_addr_o from the latched address.
  - Load: capture the lane-extracted, extended mem_rdata_i into the response register; go to RESP.
  - Word store: mem_we_o=1 with mem_wdata_o=wdata; go to RESP.
  - Sub-word store: capture mem_rdata_i with the new byte/half merged into the selected lane; go to WRITE.
- **WRITE**: mem_we_o=1, mem_wdata_o=merged word; go to RESP.
- **RESP**: rsp_valid_o=1 for exactly one cycle; go to IDLE. There is no response backpressure.
- Lane selection
  - Byte: byte at addr[1:0]×8.
  - Half: half at addr[1]×16.
  - B/H loads sign-extend; BU/HU zero-extend.
- Illegal funct3 values (011, 110, 111, and store encodings with bit 2 set) are executed as a word access.
- Address bits above ADDR_W+1 are dropped, so out-of-range addresses wrap modulo 2^ADDR_W words.
- mem_we_o and mem_addr_o are decoded from the state plus latched registers; there are no combinational paths from req_* to mem_*.

## Timing
- Reset values: state IDLE; rsp_valid_o=0, rsp_rdata_o=0, rsp_misalign_o=0, mem_we_o=0, mem_wdata_o=0, mem_addr_o=0.
- Request capture:
  - req_ready_o reads 1 while in reset, but no request is captured until rstn_i deasserts.
  - A request is accepted on edge E0 if req_valid_i & req_ready_o.
- Latency from the accept edge to the rsp_valid_o cycle:
  - Load, word store: rsp_valid_o is high in cycle E2–E3, i.e. 2 cycles after accept; the next accept is possible at E3.
  - Sub-word store: rsp_valid_o is high 3 cycles after accept.
  - Misaligned (trap enabled): rsp_valid_o is high 1 cycle after accept; no mem_we_o.
- req_ready_o=0 in ACCESS, WRITE and RESP; req_valid_i is ignored there.
- Reset mid-operation:
  - The state returns to IDLE immediately and mem_we_o drops combinationally.
  - A pending RMW write is abandoned, and no response is issued.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access (H with addr[0]=1, W with addr[1:0]≠0) skips memory.
  - The response carries rsp_misalign_o=1 and rsp_rdata_o=0.
  - Memory contents are unchanged.
- MISALIGN_TRAP_EN undefined:
  - rsp_misalign_o is tied 0.
  - Low address bits below the access size are ignored (forced alignment), e.g. LW at 0x7 reads word index 1.

## Structure
- Shared package dmem_lsu_pkg holds:
  - state enum lsu_state_t (IDLE, ACCESS, WRITE, RESP);
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module dmem_lsu_align is purely combinational. It takes word, addr[1:0], funct3 and store data, and produces the extracted/extended load value and the merged store word. The FSM stays in dmem_lsu_ctrl.

## Test plan
- SW 0xDEADBEEF at 0x10, then LW 0x10: one mem_we_o pulse at index 4; LW returns 0xDEADBEEF after 2 cycles.
- SB 0x5A at 0x13 into word 0x11223344: exactly one read then one write; the word becomes 0x5A223344; rsp_valid_o 3 cycles after accept.
- LB at 0x13 of 0x80000000 returns 0xFFFFFF80; LBU returns 0x00000080; LH at 0x12 of 0x8001xxxx returns 0xFFFF8001.
- LW at 0x02 with MISALIGN_TRAP_EN: rsp_misalign_o=1, rdata 0, mem_we_o never high. Without the macro: reads index 0, misalign=0.
- Deassert rstn_i during the WRITE state of an SH: mem_we_o drops the same cycle; the target word keeps its old value; no rsp_valid_o.
- Back-to-back requests with req_valid_i held high: req_ready_o low outside IDLE; the second request is accepted only after the first rsp_valid_o.
